// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer: captures write-back debug outputs into a show-ahead
// FIFO tagged with sequence numbers, drains over valid/ready, drops on overflow.
module wb_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          debug_wb_have_inst,
  input  logic [31:0]   debug_wb_pc,
  input  logic          debug_wb_ena,
  input  logic [4:0]    debug_wb_reg,
  input  logic [31:0]   debug_wb_value,
  output logic          tr_valid,
  input  logic          tr_ready,
  output logic [15:0]   tr_seq,
  output logic [31:0]   tr_pc,
  output logic          tr_ena,
  output logic [4:0]    tr_reg,
  output logic [31:0]   tr_value,
  input  logic          clr_ovf,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [15:0]   seq;
  logic          push_req;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          arch_write;

  // rst_n is active-high despite its name
  always_comb begin
    push_req   = debug_wb_have_inst;
    pop        = (cnt != '0) && tr_ready;
    accept     = push_req && ((cnt != FULL) || pop);
    drop       = push_req && !accept;
    arch_write = debug_wb_ena && (debug_wb_reg != '0);
    wr_entry.seq   = seq;
    wr_entry.pc    = debug_wb_pc;
    wr_entry.ena   = arch_write;
    wr_entry.rd    = arch_write ? debug_wb_reg : '0;
    wr_entry.value = arch_write ? debug_wb_value : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n && accept) begin
      mem[wptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_req) seq  <= seq + 16'd1;
      if (accept)   wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rd_entry = mem[rptr];
    tr_valid = (cnt != '0);
    count    = cnt;
    tr_seq   = tr_valid ? rd_entry.seq   : '0;
    tr_pc    = tr_valid ? rd_entry.pc    : '0;
    tr_ena   = tr_valid ? rd_entry.ena   : 1'b0;
    tr_reg   = tr_valid ? rd_entry.rd    : '0;
    tr_value = tr_valid ? rd_entry.value : '0;
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: queue-based reference model compared
// every cycle, plus directed literal checks for the key scenarios.
module tb_wb_trace_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        clk = 1'b0;
  logic        rst, have, ena, ready, clr;
  logic [31:0] pc, value;
  logic [4:0]  rg;
  logic        t_valid, t_ena, ovf;
  logic [15:0] t_seq, dcnt;
  logic [31:0] t_pc, t_value;
  logic [4:0]  t_reg;
  logic [AW:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst),
    .debug_wb_have_inst(have), .debug_wb_pc(pc), .debug_wb_ena(ena),
    .debug_wb_reg(rg), .debug_wb_value(value),
    .tr_valid(t_valid), .tr_ready(ready), .tr_seq(t_seq), .tr_pc(t_pc),
    .tr_ena(t_ena), .tr_reg(t_reg), .tr_value(t_value),
    .clr_ovf(clr), .count(cnt), .overflow(ovf), .drop_cnt(dcnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] value;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [15:0] m_seq;
  logic        m_ovf;
  logic [15:0] m_drop;
  bit          chk_en = 0;
  bit          dropped;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_seq  = 0;
      m_ovf  = 0;
      m_drop = 0;
      chk_en = 1;
    end else begin
      if (q.size() != 0 && ready) void'(q.pop_front());
      dropped = 0;
      if (have) begin
        e.seq = m_seq;
        e.pc  = pc;
        if (ena && rg != 0) begin
          e.ena = 1; e.rg = rg; e.value = value;
        end else begin
          e.ena = 0; e.rg = 0; e.value = 0;
        end
        if (q.size() < DEPTH) q.push_back(e);
        else dropped = 1;
        m_seq = m_seq + 1;
      end
      if (clr) begin
        m_ovf = 0; m_drop = 0;
      end else if (dropped) begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", cnt, q.size());
      chk("tr_valid", t_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("tr_seq", t_seq, q[0].seq);
        chk("tr_pc", t_pc, q[0].pc);
        chk("tr_ena", t_ena, q[0].ena);
        chk("tr_reg", t_reg, q[0].rg);
        chk("tr_value", t_value, q[0].value);
      end else begin
        chk("tr_data_zero", {t_seq, t_pc, t_ena, t_reg, t_value}, 0);
      end
      chk("overflow", ovf, m_ovf);
      chk("drop_cnt", dcnt, m_drop);
    end
  end

  task automatic cyc(input logic h, input logic [31:0] p, input logic en, input logic [4:0] r,
                     input logic [31:0] v, input logic rdy, input logic c, input logic rs);
    have = h; pc = p; ena = en; rg = r; value = v; ready = rdy; clr = c; rst = rs;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; have = 0; pc = 0; ena = 0; rg = 0; value = 0; ready = 0; clr = 0;
    @(negedge clk);
    chk("rst_count", cnt, 0);
    chk("rst_valid", t_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", dcnt, 0);

    // Single retire with sink ready
    cyc(1, 32'h0, 1, 5, 32'h1234, 1, 0, 0);
    chk("single_valid", t_valid, 1);
    chk("single_seq", t_seq, 0);
    chk("single_reg", t_reg, 5);
    chk("single_value", t_value, 32'h1234);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("single_gone", t_valid, 0);
    chk("single_count", cnt, 0);

    // x0 write and disabled write are normalised
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h4, 1, 0, 32'hDEAD, 0, 0, 0);
    cyc(1, 32'h8, 0, 7, 32'hBEEF, 0, 0, 0);
    chk("x0_count", cnt, 2);
    chk("x0_seq", t_seq, 0);
    chk("x0_ena", t_ena, 0);
    chk("x0_reg", t_reg, 0);
    chk("x0_value", t_value, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("dis_seq", t_seq, 1);
    chk("dis_ena", t_ena, 0);
    chk("dis_reg", t_reg, 0);
    chk("dis_value", t_value, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("x0_drained", t_valid, 0);

    // Overflow: 20 retirements into a 16-deep buffer
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 32'h100 + 4 * i, 1, 5'(i + 1), i * 3, 0, 0, 0);
    chk("ovf_count", cnt, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_drop", dcnt, 4);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_seq", t_seq, i);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
    end
    chk("ovf_empty", t_valid, 0);
    cyc(1, 32'h200, 1, 3, 32'h55, 0, 0, 0);
    chk("ovf_next_seq", t_seq, 20);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // Full with simultaneous pop
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 32'h300 + 4 * i, 1, 5'(i), i, 0, 0, 0);
    cyc(1, 32'h400, 1, 9, 32'h99, 0, 0, 0);
    chk("full_drop1", dcnt, 1);
    chk("full_head", t_seq, 0);
    cyc(1, 32'h404, 1, 9, 32'h9A, 1, 0, 0);
    chk("fullpop_count", cnt, 16);
    chk("fullpop_drop", dcnt, 1);
    chk("fullpop_seq", t_seq, 1);

    // Clear wins over a same-cycle drop, then reset mid-stream
    cyc(1, 32'h408, 1, 9, 32'h9B, 0, 1, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_drop", dcnt, 0);
    chk("clr_count", cnt, 16);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_count", cnt, 5);
    cyc(1, 32'h500, 1, 4, 32'h44, 1, 1, 1);
    chk("midrst_count", cnt, 0);
    chk("midrst_valid", t_valid, 0);
    cyc(1, 32'h504, 1, 4, 32'h45, 0, 0, 0);
    chk("midrst_seq", t_seq, 0);
    chk("midrst_pc", t_pc, 32'h504);

    // Mixed push/pop pattern
    for (int i = 0; i < 48; i++)
      cyc(i % 3 != 0, 32'h600 + 4 * i, i % 2 == 1, 5'(i), 32'hA000 + i, (i % 4) < 2, i == 30, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // Sequence wrap at 0xFFFF
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65537; i++) begin
      cyc(1, i, 1, 5'(i), i, 1, 0, 0);
      if (i == 65535) chk("wrap_ffff", t_seq, 16'hFFFF);
      if (i == 65536) chk("wrap_zero", t_seq, 16'h0000);
    end
    chk("wrap_drop", dcnt, 0);
    chk("wrap_ovf", ovf, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("wrap_empty", t_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Retirement trace buffer placed directly downstream of the pipelined CPU top. It records the write-back stage's debug outputs (`debug_wb_*`) into a show-ahead FIFO and drains them over a valid/ready stream for a trace sink such as a UART dumper or a testbench scoreboard. Each retired instruction is tagged with a sequence number. The block drops entries on overflow, reports the loss through sticky status and a counter, and never back-pressures the CPU.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `AW`, 4: pointer width; equals log2(DEPTH).
- `clk` input, 1 bit: CPU clock (`cpu_clk` at top level).
- `rst_n` input, 1 bit: reset. **One clock; reset is synchronous and active-high.** `rst_n` = 1 resets the block on the rising edge of `clk`. The port keeps the codebase name, but asserted means 1.
- `debug_wb_have_inst` input, 1 bit: WB stage holds a retiring instruction.
- `debug_wb_pc` input, 32 bits: PC of the retiring instruction.
- `debug_wb_ena` input, 1 bit: register-file write enable.
- `debug_wb_reg` input, 5 bits: destination register.
- `debug_wb_value` input, 32 bits: write-back value.
- `tr_valid` output, 1 bit: a trace entry is available.
- `tr_ready` input, 1 bit: the sink accepts the entry.
- `tr_seq` output, 16 bits: retirement sequence number of the entry.
- `tr_pc` output, 32 bits: PC of the entry.
- `tr_ena` output, 1 bit: write enable of the entry.
- `tr_reg` output, 5 bits: destination register of the entry.
- `tr_value` output, 32 bits: write-back value of the entry.
- `clr_ovf` input, 1 bit: clears `overflow` and `drop_cnt`.
- `count` output, AW+1 bits: current occupancy.
- `overflow` output, 1 bit: sticky flag, set when any retirement has been dropped.
- `drop_cnt` output, 16 bits: number of dropped retirements, saturating.

## Operation
- **Push condition.** Push is requested when `debug_wb_have_inst`=1. Cycles with it at 0 are ignored and do not advance `seq`.
- **Entry normalisation.** Applied before storage:
  - If `ena`=1 and `reg`=0, store `ena`=0, `reg`=0, `value`=0. x0 writes are not architectural.
  - If `ena`=0, store `reg`=0 and `value`=0.
- **Sequence counter.** `seq` is a 16-bit counter. It increments by 1 on every push request, whether accepted or dropped. Each stored entry takes the pre-increment value, and the counter wraps 0xFFFF→0x0000. Gaps in `tr_seq` therefore reveal drops.
- **Pop.** A pop occurs when `tr_valid`=1 and `tr_ready`=1.
- **Push acceptance.** A push is accepted when `count` < DEPTH, or when `count` = DEPTH and a pop occurs in the same cycle.
- **Rejected push.** Otherwise the push is dropped:
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 0xFFFF.
  - FIFO contents and pointers are unchanged.
- **Pointers.** Write and read pointers are AW bits and wrap modulo DEPTH.
- **Occupancy.** `count` takes +1 on push-only, -1 on pop-only, and is unchanged on simultaneous push+pop or when idle.
- **Output gating.** `tr_*` present the entry at the read pointer (show-ahead). `tr_valid` = (`count` ≠ 0). When `count`=0, all `tr_*` data outputs are driven to 0.
- **`clr_ovf` priority.** With `clr_ovf`=1, `overflow` and `drop_cnt` become 0 on that edge. A drop in the same cycle loses to the clear (clear wins). The FIFO and `seq` are unaffected.
- **Sink contract.** The sink must hold `tr_ready` stable only during its own cycle. `tr_*` must stay stable while `tr_valid`=1 and `tr_ready`=0.

## Timing
- **Reset values.** All registers and outputs, one edge after `rst_n`=1:
  - `count`=0, `tr_valid`=0, and all `tr_*` data outputs = 0.
  - `seq`=0, `overflow`=0, `drop_cnt`=0, and both pointers = 0.
- **Reset mid-operation.** Reset discards all buffered entries immediately. Push, pop and clear inputs are ignored on the reset edge.
- **Latency.** A retirement at edge N is visible on `tr_*` after edge N (`tr_valid`=1 in cycle N+1). There is no combinational input-to-output path, not even when the FIFO is empty.
- **Throughput.** The buffer sustains one push and one pop per cycle indefinitely when `tr_ready`=1.
- **Full with ready.** At full, a push with a simultaneous pop is accepted with no drop. `count` stays at DEPTH.
- **Empty with pop.** At empty, `tr_ready`=1 has no effect.

## Test plan
- **Single retire.** After reset, retire pc=0x0000_0000, ena=1, reg=5, value=0x1234 with `tr_ready`=1. Expect `tr_valid`=1 for exactly one cycle one edge later, with `tr_seq`=0, `tr_reg`=5, `tr_value`=0x1234, and `count` back to 0.
- **x0 / disabled write.** Retire ena=1, reg=0, value=0xDEAD, then ena=0, reg=7, value=0xBEEF. Expect two entries, both with `tr_ena`=0, `tr_reg`=0, `tr_value`=0, and seq 0 and 1.
- **Overflow.** Hold `tr_ready`=0 and retire 20 consecutive instructions at DEPTH=16. Expect:
  - `count`=16, `overflow`=1, `drop_cnt`=4.
  - Draining yields seq 0..15 in order, then `tr_valid`=0.
  - The next retirement carries seq 20.
- **Full with simultaneous pop.** At `count`=16, assert `tr_ready`=1 and push in the same cycle. Expect `count` to stay 16, `drop_cnt` unchanged, and the output advancing to the next seq.
- **Clear and reset mid-stream.** With `overflow`=1 and a drop in the same cycle as `clr_ovf`, expect `overflow`=0 and `drop_cnt`=0. Then assert `rst_n`=1 with 5 entries buffered; expect `count`=0, `tr_valid`=0, and the next retirement carrying seq 0.
- **Sequence wrap.** Push 65,537 retirements with `tr_ready`=1. Expect `tr_seq` to run 0xFFFF then 0x0000 with no drops.
